// File: rtl/action_collector_if.sv
// Player/game-core handshake bundle for action_collector.
// The DUT side uses modport slave; the player/bench side uses modport master.
interface action_collector_if;
  logic [2:0] p1Action;
  logic       p1Valid;
  logic       p1Ready;
  logic [2:0] p2Action;
  logic       p2Valid;
  logic       p2Ready;
  logic       gameOver;
  logic [2:0] action1;
  logic [2:0] action2;
  logic       actionEnable;
  logic [7:0] roundCount;
  logic       timeoutFlag;

  modport slave (
    input  p1Action, p1Valid, p2Action, p2Valid, gameOver,
    output p1Ready, p2Ready, action1, action2, actionEnable, roundCount, timeoutFlag
  );

  modport master (
    output p1Action, p1Valid, p2Action, p2Valid, gameOver,
    input  p1Ready, p2Ready, action1, action2, actionEnable, roundCount, timeoutFlag
  );
endinterface

// File: rtl/action_collector.sv
// action_collector: pairs one commit from each player, then issues the pair to
// the game core as an actionEnable pulse followed by a cooldown window.
// Optional feature macro ACTION_TIMEOUT_EN: auto-fills a missing commit with
// the no-op code after TIMEOUT_CYCLES and pulses timeoutFlag.
module action_collector #(
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned ENABLE_CYCLES   = 1,
  parameter int unsigned COOLDOWN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                resetGame,
  action_collector_if.slave   bus
);

  localparam int unsigned ACT_W    = 3;
  localparam int unsigned RND_W    = 8;
  localparam int unsigned CNT_MAX0 = (ENABLE_CYCLES > COOLDOWN_CYCLES) ? ENABLE_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES > CNT_MAX0) ? TIMEOUT_CYCLES : CNT_MAX0;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] EN_LAST = CNT_W'(ENABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
`ifdef ACTION_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_ISSUE    = 2'd1,
    S_COOLDOWN = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               full1_q, full1_d;
  logic               full2_q, full2_d;
  logic [ACT_W-1:0]   slot1_q, slot1_d;
  logic [ACT_W-1:0]   slot2_q, slot2_d;
  logic [ACT_W-1:0]   act1_q, act1_d;
  logic [ACT_W-1:0]   act2_q, act2_d;
  logic               en_q, en_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               tflag_q, tflag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy1_q, rdy1_d;
  logic               rdy2_q, rdy2_d;
  logic               issue;
  logic               acc1, acc2;

  // A commit lands only when the registered ready was high; no buffering otherwise.
  assign acc1 = bus.p1Valid & rdy1_q;
  assign acc2 = bus.p2Valid & rdy2_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    full1_d = full1_q;
    full2_d = full2_q;
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    act1_d  = act1_q;
    act2_d  = act2_q;
    en_d    = en_q;
    round_d = round_q;
    tflag_d = 1'b0;
    cnt_d   = cnt_q;
    issue   = 1'b0;

    if (bus.gameOver) begin
      // Game over aborts everything; issued actions and round count are kept.
      state_d = S_HALT;
      full1_d = 1'b0;
      full2_d = 1'b0;
      en_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          if (acc1) begin
            full1_d = 1'b1;
            slot1_d = bus.p1Action;
          end
          if (acc2) begin
            full2_d = 1'b1;
            slot2_d = bus.p2Action;
          end
          if (full1_d && full2_d) begin
            issue  = 1'b1;
            act1_d = slot1_d;
            act2_d = slot2_d;
          end
`ifdef ACTION_TIMEOUT_EN
          else if (full1_d ^ full2_d) begin
            // Timer restarts on the first commit and runs while one slot waits.
            if (acc1 || acc2) begin
              cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
              issue   = 1'b1;
              tflag_d = 1'b1;
              act1_d  = full1_q ? slot1_q : '0;
              act2_d  = full2_q ? slot2_q : '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`endif
          if (issue) begin
            state_d = S_ISSUE;
            en_d    = 1'b1;
            round_d = round_q + RND_W'(1);
            cnt_d   = '0;
            full1_d = 1'b0;
            full2_d = 1'b0;
          end
        end
        S_ISSUE: begin
          if (cnt_q == EN_LAST) begin
            en_d    = 1'b0;
            cnt_d   = '0;
            state_d = (COOLDOWN_CYCLES == 0) ? S_COLLECT : S_COOLDOWN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_COOLDOWN: begin
          if (cnt_q == CD_LAST) begin
            cnt_d   = '0;
            state_d = S_COLLECT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HALT: begin
          state_d = S_COLLECT;
        end
        default: begin
          state_d = S_COLLECT;
        end
      endcase
    end

    // Ready is registered, so it reflects the state being entered.
    rdy1_d = (state_d == S_COLLECT) && !full1_d;
    rdy2_d = (state_d == S_COLLECT) && !full2_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetGame) begin
      state_q <= S_COLLECT;
      full1_q <= 1'b0;
      full2_q <= 1'b0;
      slot1_q <= '0;
      slot2_q <= '0;
      act1_q  <= '0;
      act2_q  <= '0;
      en_q    <= 1'b0;
      round_q <= '0;
      tflag_q <= 1'b0;
      cnt_q   <= '0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      full1_q <= full1_d;
      full2_q <= full2_d;
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      en_q    <= en_d;
      round_q <= round_d;
      tflag_q <= tflag_d;
      cnt_q   <= cnt_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
    end
  end

  assign bus.p1Ready      = rdy1_q;
  assign bus.p2Ready      = rdy2_q;
  assign bus.action1      = act1_q;
  assign bus.action2      = act2_q;
  assign bus.actionEnable = en_q;
  assign bus.roundCount   = round_q;
  assign bus.timeoutFlag  = tflag_q;

endmodule

// File: tb/tb_action_collector.sv
// Directed bench for action_collector: a default-parameter instance (a) and a
// long-pulse, zero-cooldown instance (b) used for the game-over abort case.
module tb_action_collector;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_errors;
  logic seen_en;

  action_collector_if bus_a ();
  action_collector_if bus_b ();

  action_collector #(
    .TIMEOUT_CYCLES (16),
    .ENABLE_CYCLES  (1),
    .COOLDOWN_CYCLES(2)
  ) dut_a (
    .clk      (clk),
    .resetGame(rst_a),
    .bus      (bus_a)
  );

  action_collector #(
    .TIMEOUT_CYCLES (16),
    .ENABLE_CYCLES  (4),
    .COOLDOWN_CYCLES(0)
  ) dut_b (
    .clk      (clk),
    .resetGame(rst_b),
    .bus      (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    seen_en  = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.p1Action = 3'd0; bus_a.p1Valid = 1'b0;
    bus_a.p2Action = 3'd0; bus_a.p2Valid = 1'b0;
    bus_a.gameOver = 1'b0;
    bus_b.p1Action = 3'd0; bus_b.p1Valid = 1'b0;
    bus_b.p2Action = 3'd0; bus_b.p2Valid = 1'b0;
    bus_b.gameOver = 1'b0;

    // Reset state
    step(); step();
    chk("rst_p1ready", 8'(bus_a.p1Ready), 8'd0);
    chk("rst_p2ready", 8'(bus_a.p2Ready), 8'd0);
    chk("rst_enable",  8'(bus_a.actionEnable), 8'd0);
    chk("rst_round",   bus_a.roundCount, 8'd0);
    chk("rst_action1", 8'(bus_a.action1), 8'd0);
    chk("rst_tflag",   8'(bus_a.timeoutFlag), 8'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();
    chk("rel_p1ready", 8'(bus_a.p1Ready), 8'd1);
    chk("rel_p2ready", 8'(bus_a.p2Ready), 8'd1);
    chk("rel_b_ready", 8'(bus_b.p1Ready), 8'd1);

    // Staggered commits 110 then 100
    bus_a.p1Action = 3'b110; bus_a.p1Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0;
    chk("stag_p1ready", 8'(bus_a.p1Ready), 8'd0);
    chk("stag_p2ready", 8'(bus_a.p2Ready), 8'd1);
    chk("stag_en_early", 8'(bus_a.actionEnable), 8'd0);
    step();
    bus_a.p2Action = 3'b100; bus_a.p2Valid = 1'b1;
    step();
    bus_a.p2Valid = 1'b0;
    chk("stag_en",      8'(bus_a.actionEnable), 8'd1);
    chk("stag_action1", 8'(bus_a.action1), 8'h6);
    chk("stag_action2", 8'(bus_a.action2), 8'h4);
    chk("stag_round",   bus_a.roundCount, 8'd1);
    chk("stag_rdy_iss", 8'(bus_a.p1Ready), 8'd0);
    step();
    chk("stag_en_off",  8'(bus_a.actionEnable), 8'd0);
    chk("stag_hold_a1", 8'(bus_a.action1), 8'h6);
    step();
    chk("stag_cd_rdy",  8'(bus_a.p1Ready), 8'd0);
    step();
    chk("stag_col_rdy1", 8'(bus_a.p1Ready), 8'd1);
    chk("stag_col_rdy2", 8'(bus_a.p2Ready), 8'd1);

    // Simultaneous commits 001 / 011
    bus_a.p1Action = 3'b001; bus_a.p1Valid = 1'b1;
    bus_a.p2Action = 3'b011; bus_a.p2Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0; bus_a.p2Valid = 1'b0;
    chk("sim_en",      8'(bus_a.actionEnable), 8'd1);
    chk("sim_action1", 8'(bus_a.action1), 8'h1);
    chk("sim_action2", 8'(bus_a.action2), 8'h3);
    chk("sim_round",   bus_a.roundCount, 8'd2);
    chk("sim_rdy1",    8'(bus_a.p1Ready), 8'd0);
    chk("sim_rdy2",    8'(bus_a.p2Ready), 8'd0);
    step();
    chk("sim_en_off",  8'(bus_a.actionEnable), 8'd0);
    chk("sim_cd1_rdy", 8'(bus_a.p2Ready), 8'd0);
    step();
    chk("sim_cd2_rdy", 8'(bus_a.p2Ready), 8'd0);
    step();
    chk("sim_col_rdy", 8'(bus_a.p2Ready), 8'd1);

    // Re-asserted p1Valid after its slot is full is ignored
    bus_a.p1Action = 3'b101; bus_a.p1Valid = 1'b1;
    step();
    bus_a.p1Action = 3'b111;
    chk("dup_rdy1", 8'(bus_a.p1Ready), 8'd0);
    step(); step();
    bus_a.p2Action = 3'b010; bus_a.p2Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0; bus_a.p2Valid = 1'b0;
    chk("dup_en",      8'(bus_a.actionEnable), 8'd1);
    chk("dup_action1", 8'(bus_a.action1), 8'h5);
    chk("dup_action2", 8'(bus_a.action2), 8'h2);
    chk("dup_round",   bus_a.roundCount, 8'd3);
    step(); step(); step();

    // gameOver while p2 slot is full clears it
    bus_a.p2Action = 3'b100; bus_a.p2Valid = 1'b1;
    step();
    bus_a.p2Valid = 1'b0;
    bus_a.gameOver = 1'b1;
    step();
    chk("go_rdy1", 8'(bus_a.p1Ready), 8'd0);
    chk("go_rdy2", 8'(bus_a.p2Ready), 8'd0);
    bus_a.gameOver = 1'b0;
    step();
    chk("go_rel_rdy2", 8'(bus_a.p2Ready), 8'd1);
    chk("go_round",    bus_a.roundCount, 8'd3);
    bus_a.p1Action = 3'b111; bus_a.p1Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0;
    chk("go_slot_clear_en", 8'(bus_a.actionEnable), 8'd0);

    // Reset mid-COLLECT with p1 slot full
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("mrst_rdy1",  8'(bus_a.p1Ready), 8'd0);
    chk("mrst_round", bus_a.roundCount, 8'd0);
    chk("mrst_act1",  8'(bus_a.action1), 8'd0);
    step();
    chk("mrst_rel_rdy1", 8'(bus_a.p1Ready), 8'd1);
    bus_a.p2Action = 3'b110; bus_a.p2Valid = 1'b1;
    step();
    bus_a.p2Valid = 1'b0;
    chk("mrst_half_en", 8'(bus_a.actionEnable), 8'd0);
    bus_a.p1Action = 3'b011; bus_a.p1Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0;
    chk("mrst_en",      8'(bus_a.actionEnable), 8'd1);
    chk("mrst_action1", 8'(bus_a.action1), 8'h3);
    chk("mrst_action2", 8'(bus_a.action2), 8'h6);
    chk("mrst_round",   bus_a.roundCount, 8'd1);
    step(); step(); step();

    // Round counter wrap: 255 more rounds from 1
    for (int i = 0; i < 254; i++) begin
      bus_a.p1Valid = 1'b1; bus_a.p2Valid = 1'b1;
      step();
      bus_a.p1Valid = 1'b0; bus_a.p2Valid = 1'b0;
      step(); step(); step();
    end
    chk("wrap_255", bus_a.roundCount, 8'd255);
    bus_a.p1Valid = 1'b1; bus_a.p2Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0; bus_a.p2Valid = 1'b0;
    chk("wrap_0", bus_a.roundCount, 8'd0);
    chk("wrap_en", 8'(bus_a.actionEnable), 8'd1);
    step(); step(); step();

`ifdef ACTION_TIMEOUT_EN
    // p2 silent: auto-fill after 16 cycles
    bus_a.p1Action = 3'b001; bus_a.p1Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0;
    seen_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen_en = seen_en | bus_a.actionEnable;
    end
    chk("to_early_en", 8'(seen_en), 8'd0);
    step();
    chk("to_en",      8'(bus_a.actionEnable), 8'd1);
    chk("to_tflag",   8'(bus_a.timeoutFlag), 8'd1);
    chk("to_action1", 8'(bus_a.action1), 8'h1);
    chk("to_action2", 8'(bus_a.action2), 8'h0);
    chk("to_round",   bus_a.roundCount, 8'd1);
    step();
    chk("to_tflag_off", 8'(bus_a.timeoutFlag), 8'd0);
    step(); step();
    // Late commit on the expiry edge wins
    bus_a.p1Action = 3'b010; bus_a.p1Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    bus_a.p2Action = 3'b101; bus_a.p2Valid = 1'b1;
    step();
    bus_a.p2Valid = 1'b0;
    chk("tol_en",      8'(bus_a.actionEnable), 8'd1);
    chk("tol_action2", 8'(bus_a.action2), 8'h5);
    chk("tol_tflag",   8'(bus_a.timeoutFlag), 8'd0);
    step(); step(); step();
`else
    // Without timeout the lone commit waits forever
    bus_a.p1Action = 3'b001; bus_a.p1Valid = 1'b1;
    step();
    bus_a.p1Valid = 1'b0;
    seen_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      seen_en = seen_en | bus_a.actionEnable | bus_a.timeoutFlag;
    end
    chk("nto_seen_en", 8'(seen_en), 8'd0);
    chk("nto_rdy2",    8'(bus_a.p2Ready), 8'd1);
    chk("nto_round",   bus_a.roundCount, 8'd0);
`endif

    // Instance b: gameOver aborts a 4-cycle pulse
    bus_b.p1Action = 3'b010; bus_b.p1Valid = 1'b1;
    bus_b.p2Action = 3'b100; bus_b.p2Valid = 1'b1;
    step();
    bus_b.p1Valid = 1'b0; bus_b.p2Valid = 1'b0;
    chk("b_en1",   8'(bus_b.actionEnable), 8'd1);
    chk("b_round", bus_b.roundCount, 8'd1);
    step();
    chk("b_en2", 8'(bus_b.actionEnable), 8'd1);
    bus_b.gameOver = 1'b1;
    step();
    chk("b_go_en",   8'(bus_b.actionEnable), 8'd0);
    chk("b_go_rdy1", 8'(bus_b.p1Ready), 8'd0);
    chk("b_go_rdy2", 8'(bus_b.p2Ready), 8'd0);
    step();
    chk("b_halt_rdy1", 8'(bus_b.p1Ready), 8'd0);
    bus_b.gameOver = 1'b0;
    step();
    chk("b_rel_rdy1",  8'(bus_b.p1Ready), 8'd1);
    chk("b_rel_rdy2",  8'(bus_b.p2Ready), 8'd1);
    chk("b_rel_round", bus_b.roundCount, 8'd1);
    bus_b.p1Action = 3'b001; bus_b.p1Valid = 1'b1;
    step();
    bus_b.p1Valid = 1'b0;
    chk("b_half_en", 8'(bus_b.actionEnable), 8'd0);
    bus_b.p2Action = 3'b011; bus_b.p2Valid = 1'b1;
    step();
    bus_b.p2Valid = 1'b0;
    chk("b2_en",      8'(bus_b.actionEnable), 8'd1);
    chk("b2_action1", 8'(bus_b.action1), 8'h1);
    chk("b2_action2", 8'(bus_b.action2), 8'h3);
    chk("b2_round",   bus_b.roundCount, 8'd2);
    step(); step(); step();
    chk("b2_en_last", 8'(bus_b.actionEnable), 8'd1);
    step();
    chk("b2_en_off",  8'(bus_b.actionEnable), 8'd0);
    chk("b2_nocd_rdy", 8'(bus_b.p1Ready), 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/action_collector.md
ACTION_COLLECTOR -- requirements
Module: action_collector

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, cycles to wait for the second player after the first commits (ACTION_TIMEOUT_EN only).
REQ-002 SHALL have parameter: ENABLE_CYCLES, 1, width of the actionEnable pulse in cycles (legal range 1-15).
REQ-003 SHALL have parameter: COOLDOWN_CYCLES, 2, idle cycles after a pulse before new commits are accepted (legal range 0-15).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; resetGame in 1, synchronous active-high reset.
REQ-005 SHALL have the following player 1 inputs: p1Action in 3, player 1 action code; p1Valid in 1, player 1 commit request.
REQ-006 SHALL have the following player 2 inputs: p2Action in 3, player 2 action code; p2Valid in 1, player 2 commit request.
REQ-007 SHALL have input gameOver in 1, driven by firstWin|secondWin of the downstream game core.
REQ-008 SHALL have outputs p1Ready out 1 and p2Ready out 1, each high when that player's slot can accept a commit.
REQ-009 SHALL have outputs action1 out 3 and action2 out 3, carrying the paired actions to the game core.
REQ-010 SHALL have output actionEnable out 1, asserted while the game core is to consume action1/action2.
REQ-011 SHALL have output roundCount out 8, counting issued rounds and wrapping from 255 to 0.
REQ-012 SHALL have output timeoutFlag out 1, pulsing when a slot was auto-filled.

Function
REQ-013 SHALL implement states COLLECT, ISSUE, COOLDOWN and HALT, with all outputs registered.
REQ-014 SHALL accept player N's commit when pNValid and pNReady are both high at a clk edge; pNAction SHALL be latched into slot N.
REQ-015 SHALL drive pNReady high only in COLLECT with slot N empty and gameOver low.
REQ-016 SHALL accept both commits in a single cycle when both players are valid and ready in the same cycle.
REQ-017 SHALL move from COLLECT to ISSUE on the edge where the second slot becomes full; action1/action2 SHALL take the slot values and actionEnable SHALL rise on the following cycle.
REQ-018 SHALL hold actionEnable high for exactly ENABLE_CYCLES cycles in ISSUE, then enter COOLDOWN with actionEnable low.
REQ-019 SHALL hold action1/action2 stable from ISSUE entry until the next ISSUE entry.
REQ-020 SHALL stay in COOLDOWN for COOLDOWN_CYCLES cycles, then enter COLLECT with both slots empty; with COOLDOWN_CYCLES=0 it SHALL go from ISSUE directly to COLLECT.
REQ-021 SHALL increment roundCount on each ISSUE entry.
REQ-022 SHALL enter HALT on the next edge whenever gameOver is high, from any state: actionEnable SHALL go low (aborting any pulse), both slots SHALL clear, and roundCount SHALL hold.
REQ-023 SHALL leave HALT for COLLECT on the first edge with gameOver low.
REQ-024 SHALL ignore pNValid while the matching pNReady is low, with no buffering.

Reset
REQ-025 SHALL, on a clk edge with resetGame high, set the state to COLLECT, clear both slots, and set action1=3'b000, action2=3'b000, actionEnable=0, roundCount=0 and timeoutFlag=0, with the timeout counter cleared.
REQ-026 SHALL drive p1Ready=p2Ready=0 during reset and high from the first cycle after reset releases (if gameOver is low).
REQ-027 SHALL give resetGame priority over gameOver and all commits, including reset mid-ISSUE, which drops actionEnable on the next cycle.

Configuration
REQ-028 SHALL, with macro ACTION_TIMEOUT_EN defined, start a counter when exactly one slot is full in COLLECT.
REQ-029 SHALL, when that counter reaches TIMEOUT_CYCLES, fill the empty slot with 3'b000 (no-op) and enter ISSUE, with timeoutFlag high for 1 cycle coincident with the first actionEnable cycle.
REQ-030 SHALL, if the missing commit arrives on the expiry edge itself, use the real action and keep timeoutFlag low.
REQ-031 SHALL, with ACTION_TIMEOUT_EN undefined, have no counter, wait indefinitely in COLLECT, and tie timeoutFlag to 0.

Verification
REQ-032 SHALL cover: reset released, p1 commits 3'b110 at cycle 2, p2 commits 3'b100 at cycle 4 -> action1=110, action2=100, actionEnable high at cycle 5 only, roundCount=1.
REQ-033 SHALL cover: both valid same cycle with 3'b001/3'b011 -> both accepted, actionEnable high on the next cycle, readies low until COOLDOWN (2 cycles) ends.
REQ-034 SHALL cover: with ACTION_TIMEOUT_EN, p1 commits 3'b001, p2 silent -> 16 cycles later action2=3'b000, timeoutFlag=1 with actionEnable; without the macro -> no actionEnable after 100 cycles.
REQ-035 SHALL cover: gameOver raised during an ENABLE_CYCLES=4 pulse -> actionEnable low next cycle, readies low; gameOver dropped -> readies high next cycle, slots empty.
REQ-036 SHALL cover: 256 rounds issued -> roundCount wraps to 0; resetGame asserted mid-COLLECT with p1 slot full -> slot cleared, next pair issued fresh.
REQ-037 SHALL cover: p1Valid re-asserted after p1 slot full -> ignored; action1 keeps the first value.
